load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 47 ++++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, fault codes,
// FSM state type and small op-decoding helpers.
package lsu_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCESS = 2'd1;
    localparam state_t S_RESP   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-bus signals of the load/store unit.
// slave = the LSU's view, master = the requester/memory side.
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic [1:0]        fault;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  start, op, addr, wdata, mem_rdata, mem_ack,
        output busy, done, rdata, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output start, op, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, rdata, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load aligner: moves the addressed lane down to bit 0 and
// sign/zero-extends it according to the load op. Stores produce 0.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    output logic [31:0] result
);
    logic [31:0] shifted;

    assign shifted = mem_rdata >> {offset, 3'b000};

    always_comb begin
        result = '0;
        case (op)
            OP_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU: result = {24'd0, shifted[7:0]};
            OP_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU: result = {16'd0, shifted[15:0]};
            OP_LW:  result = mem_rdata;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned requests instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        fault_q, fault_d;

    logic [1:0]  req_sz, aoff;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        trap;
    logic [31:0] ld_result;

    lsu_load_align u_align (
        .mem_rdata (bus.mem_rdata),
        .op        (op_q),
        .offset    (off_q),
        .result    (ld_result)
    );

    assign req_sz = op_size(bus.op);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(bus.op, bus.addr[1:0]);
    assign aoff = bus.addr[1:0];
`else
    // Offending low bits are dropped so the access always proceeds aligned.
    assign trap = 1'b0;
    assign aoff = (req_sz == SZ_WORD) ? 2'b00 :
                  (req_sz == SZ_HALF) ? {bus.addr[1], 1'b0} : bus.addr[1:0];
`endif

    always_comb begin
        req_be = 4'b1111;
        req_wd = bus.wdata;
        case (req_sz)
            SZ_BYTE: begin req_be = 4'b0001 << aoff; req_wd = {4{bus.wdata[7:0]}};  end
            SZ_HALF: begin req_be = 4'b0011 << aoff; req_wd = {2{bus.wdata[15:0]}}; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        we_d    = we_q;
        be_d    = be_q;
        maddr_d = maddr_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d  = bus.op;
                off_d = aoff;
                if (trap) begin
                    state_d = S_RESP;
                    fault_d = FAULT_MISALIGN;
                    rdata_d = '0;
                end else begin
                    state_d = S_ACCESS;
                    we_d    = is_store(bus.op);
                    be_d    = req_be;
                    maddr_d = {bus.addr[ADDR_W-1:2], 2'b00};
                    wdat_d  = is_store(bus.op) ? req_wd : '0;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus.mem_ack || (cnt_q + 8'd1 == TO_LIM)) begin
                    state_d = S_RESP;
                    rdata_d = bus.mem_ack ? ld_result : '0;
                    fault_d = bus.mem_ack ? FAULT_NONE : FAULT_TIMEOUT;
                    we_d    = 1'b0;
                    be_d    = '0;
                    maddr_d = '0;
                    wdat_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = '0;
                fault_d = FAULT_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            maddr_q <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            we_q    <= we_d;
            be_q    <= be_d;
            maddr_q <= maddr_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_RESP);
    assign bus.mem_req   = (state_q == S_ACCESS);
    assign bus.rdata     = rdata_q;
    assign bus.fault     = fault_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdat_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued when a
// request is issued and popped when done is observed.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // wait_n: ACCESS cycles without ack before acking (-1 = never ack).
    // poke: re-assert start during ACCESS; it must be ignored.
    task automatic txn(input string name, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdat, input int wait_n,
                       input logic [31:0] exp_rd, input logic [1:0] exp_f, input int exp_lat,
                       input int exp_reqs, input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                       input logic exp_we, input logic chk_wd, input logic [31:0] exp_wd,
                       input logic poke);
        exp_t e;
        int   cyc;
        int   reqs;
        logic got;
        e.rdata = exp_rd; e.fault = exp_f; e.lat = exp_lat; e.reqs = exp_reqs;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; reqs = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.mem_ack = 1'b0;
            bus.start   = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                if (sb.size() > 0) e = sb.pop_front();
                chk({name, ".rdata"}, bus.rdata, e.rdata);
                chk({name, ".fault"}, bus.fault, e.fault);
                chk({name, ".latency"}, cyc, e.lat);
                chk({name, ".req_cycles"}, reqs, e.reqs);
            end else if (bus.mem_req) begin
                reqs++;
                chk({name, ".bus"}, {bus.mem_we, bus.mem_be, bus.mem_addr}, {exp_we, exp_be, exp_maddr});
                if (chk_wd) chk({name, ".wdata"}, bus.mem_wdata, exp_wd);
                if (poke && reqs == 1) begin
                    bus.start = 1'b1; bus.op = OP_SB; bus.addr = 32'h0;
                end
                if (reqs - 1 == wait_n) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdat;
                end
            end
        end
        if (!got) begin
            n_chk++;
            assert (got) else begin
                n_fail++;
                $error("FAIL %s.done: observed no done within %0d cycles, expected done", name, cyc);
            end
            if (sb.size() > 0) void'(sb.pop_front());
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk({name, ".idle_after"}, {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.status", {bus.busy, bus.done, bus.fault, bus.rdata}, '0);
        chk("rst.mem", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata}, '0);
        chk("rst.addr", bus.mem_addr, '0);
        reset = 1'b0;

        // ack while idle must be ignored
        bus.mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack", {bus.busy, bus.done, bus.mem_req}, 3'b000);
        end
        bus.mem_ack = 1'b0;

        txn("lb_103",  OP_LB,  32'h103, 32'h0, 32'h80FF_1234, 0, 32'hFFFF_FF80, FAULT_NONE, 2, 1,
            32'h100, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lhu_102", OP_LHU, 32'h102, 32'h0, 32'h9ABC_0000, 3, 32'h0000_9ABC, FAULT_NONE, 5, 4,
            32'h100, 4'b1100, 1'b0, 1'b0, 32'h0, 1'b1);
        txn("sh_202",  OP_SH,  32'h202, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 32'h0, FAULT_NONE, 2, 1,
            32'h200, 4'b1100, 1'b1, 1'b1, 32'hBEEF_BEEF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        txn("lw_101",  OP_LW,  32'h101, 32'h0, 32'h1234_5678, 0, 32'h0, FAULT_MISALIGN, 1, 0,
            32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lh_105",  OP_LH,  32'h105, 32'h0, 32'h0000_FFFE, 0, 32'h0, FAULT_MISALIGN, 1, 0,
            32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
`else
        txn("lw_101",  OP_LW,  32'h101, 32'h0, 32'h1234_5678, 0, 32'h1234_5678, FAULT_NONE, 2, 1,
            32'h100, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lh_105",  OP_LH,  32'h105, 32'h0, 32'h0000_FFFE, 0, 32'hFFFF_FFFE, FAULT_NONE, 2, 1,
            32'h104, 4'b0011, 1'b0, 1'b0, 32'h0, 1'b0);
`endif
        txn("lw_to",   OP_LW,  32'h300, 32'h0, 32'h0, -1, 32'h0, FAULT_TIMEOUT, 16, 15,
            32'h300, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lw_ack15", OP_LW, 32'h304, 32'h0, 32'hCAFE_F00D, 14, 32'hCAFE_F00D, FAULT_NONE, 16, 15,
            32'h304, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lb_001",  OP_LB,  32'h001, 32'h0, 32'h0000_7F00, 0, 32'h0000_007F, FAULT_NONE, 2, 1,
            32'h000, 4'b0010, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lbu_002", OP_LBU, 32'h002, 32'h0, 32'h00F0_0000, 1, 32'h0000_00F0, FAULT_NONE, 3, 2,
            32'h000, 4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("lh_000",  OP_LH,  32'h000, 32'h0, 32'h1234_8001, 0, 32'hFFFF_8001, FAULT_NONE, 2, 1,
            32'h000, 4'b0011, 1'b0, 1'b0, 32'h0, 1'b0);
        txn("sb_003",  OP_SB,  32'h003, 32'h1234_56A5, 32'h5555_5555, 0, 32'h0, FAULT_NONE, 2, 1,
            32'h000, 4'b1000, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        txn("sw_010",  OP_SW,  32'h010, 32'hDEAD_BEEF, 32'h0, 2, 32'h0, FAULT_NONE, 4, 3,
            32'h010, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // reset in the second ACCESS cycle abandons the transfer
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_LW; bus.addr = 32'h400;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_acc.req1", bus.mem_req, 1'b1);
        @(negedge clk);
        chk("rst_acc.req2", bus.mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            chk("rst_acc.status", {bus.busy, bus.done, bus.fault, bus.rdata}, '0);
            chk("rst_acc.mem", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata}, '0);
            chk("rst_acc.addr", bus.mem_addr, '0);
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        txn("lw_after", OP_LW, 32'h408, 32'h0, 32'h0BAD_CAFE, 0, 32'h0BAD_CAFE, FAULT_NONE, 2, 1,
            32'h408, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
